// File: rtl/pcs_pkg.sv
// Shared 10G PCS definitions: sync header codes, scrambler taps, descrambler state.
// Pure declarations; no timing or flow control of its own.
package pcs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;

    typedef enum logic {
        UNLOCKED,
        RUN
    } dscr_state_t;

    // Only 01 and 10 are legal 64b/66b sync headers.
    function automatic logic hdr_bad(input logic [1:0] hdr);
        return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
    endfunction

endpackage

// File: rtl/descrambler_if.sv
// Block stream into and out of the descrambler; master drives in_*, slave drives out_*.
// No ready: the receive path cannot be stalled, qualification is by *_valid only.
interface descrambler_if #(
    parameter int W = 64
);
    logic [W-1:0] in_data;
    logic [1:0]   in_header;
    logic         in_data_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_header;
    logic         out_data_valid;
    logic         out_hdr_err;

    modport master (
        output in_data, in_header, in_data_valid,
        input  out_data, out_header, out_data_valid, out_hdr_err
    );

    modport slave (
        input  in_data, in_header, in_data_valid,
        output out_data, out_header, out_data_valid, out_hdr_err
    );
endinterface

// File: rtl/ber_monitor.sv
// Windowed sync-header error monitor raising hi_ber; hi_ber updates one cycle after the block.
// No backpressure: every blk_valid block is counted the cycle it arrives.
module ber_monitor #(
    parameter int BER_WINDOW = 19531,
    parameter int BER_THRESH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic blk_valid,
    input  logic hdr_err,
    input  logic win_clr,
    output logic hi_ber
);
    localparam int CW = $clog2(BER_WINDOW + 1);
    localparam int EW = $clog2(BER_THRESH + 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(BER_WINDOW - 1);
    localparam logic [EW-1:0] THRESH   = EW'(BER_THRESH);

    logic [CW-1:0] win_cnt;
    logic [EW-1:0] win_err;
    logic [EW-1:0] win_err_nxt;

    always_comb begin
        win_err_nxt = win_err;
        if (hdr_err && (win_err != THRESH)) begin
            win_err_nxt = win_err + 1'b1;
        end
    end

    // hi_ber is sticky across windows until a window ends below threshold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt <= '0;
            win_err <= '0;
            hi_ber  <= 1'b0;
        end else if (win_clr) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (blk_valid) begin
            if (win_err_nxt == THRESH) begin
                hi_ber <= 1'b1;
            end
            if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
                if (win_err_nxt != THRESH) begin
                    hi_ber <= 1'b0;
                end
            end else begin
                win_cnt <= win_cnt + 1'b1;
                win_err <= win_err_nxt;
            end
        end
    end

endmodule

// File: rtl/descrambler.sv
// 64b/66b self-synchronizing descrambler (x^58+x^39+1) with sync-header monitoring.
// Latency 1 cycle; no backpressure, output valid follows accepted input valid.
module descrambler
    import pcs_pkg::*;
#(
    parameter int PCS_DATA_WIDTH = 64,
    parameter int BER_WINDOW     = 19531,
    parameter int BER_THRESH     = 16,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    descrambler_if.slave             dif,
    input  logic                     block_lock,
    input  logic                     err_count_clr,
    output logic                     hi_ber,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);
    localparam int W = PCS_DATA_WIDTH;

    dscr_state_t state;

    // Only the top SCR_TAP_B bits of the previous block ever reach a tap.
    logic [SCR_TAP_B-1:0]   hist;
    logic [W+SCR_TAP_B-1:0] ext;
    logic [W-1:0]           dscr;
    logic                   accept;
    logic                   run_blk;
    logic                   hdr_err;
    logic                   run_err;

    assign ext     = {dif.in_data, hist};
    assign accept  = dif.in_data_valid & block_lock;
    assign run_blk = accept & (state == RUN);
    assign hdr_err = hdr_bad(dif.in_header);
    assign run_err = run_blk & hdr_err;

    for (genvar i = 0; i < W; i++) begin : g_dscr
        assign dscr[i] = ext[SCR_TAP_B + i]
                       ^ ext[SCR_TAP_B + i - SCR_TAP_A]
                       ^ ext[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= UNLOCKED;
            hist               <= '1;
            dif.out_data       <= '0;
            dif.out_header     <= '0;
            dif.out_data_valid <= 1'b0;
            dif.out_hdr_err    <= 1'b0;
            err_count          <= '0;
        end else begin
            dif.out_data_valid <= run_blk;
            dif.out_hdr_err    <= run_err;
            if (accept) begin
                hist           <= dif.in_data[W-1:W-SCR_TAP_B];
                dif.out_data   <= dscr;
                dif.out_header <= dif.in_header;
            end

            // The first accepted block after lock only seeds the history.
            if (!block_lock) begin
                state <= UNLOCKED;
            end else if (dif.in_data_valid) begin
                state <= RUN;
            end

            if (err_count_clr) begin
                err_count <= {{(ERR_CNT_WIDTH-1){1'b0}}, run_err};
            end else if (run_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    ber_monitor #(
        .BER_WINDOW (BER_WINDOW),
        .BER_THRESH (BER_THRESH)
    ) u_ber (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (run_blk),
        .hdr_err   (hdr_err),
        .win_clr   (!block_lock),
        .hi_ber    (hi_ber)
    );

endmodule

// File: tb/tb_descrambler.sv
// Loopback bench: serial scrambler model feeds the descrambler, scoreboard checks decoded blocks.
module tb_descrambler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       block_lock = 1'b0;
    logic       err_count_clr = 1'b0;
    logic       hi_ber;
    logic [3:0] err_count;

    descrambler_if #(.W(64)) dif ();

    descrambler #(
        .PCS_DATA_WIDTH (64),
        .BER_WINDOW     (8),
        .BER_THRESH     (3),
        .ERR_CNT_WIDTH  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dif           (dif),
        .block_lock    (block_lock),
        .err_count_clr (err_count_clr),
        .hi_ber        (hi_ber),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0] hdr;
        logic       exp_err;
        logic [3:0] exp_cnt;
    } hv_t;

    exp_t        sb[$];
    hv_t         tv[6];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] scr_prev = '1;
    bit          seeded = 1'b0;
    int          m_cnt = 0;
    int          m_wc = 0;
    int          m_we = 0;
    bit          m_hi = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_bad(input logic [1:0] h);
        return (h == 2'b00) || (h == 2'b11);
    endfunction

    // Bit-serial transmit scrambler: each output bit feeds back into later ones.
    function automatic logic [63:0] scramble(input logic [63:0] p, input logic [63:0] prev);
        logic [127:0] e;
        e = {64'h0, prev};
        for (int i = 0; i < 64; i++) begin
            e[64+i] = p[i] ^ e[64+i-39] ^ e[64+i-58];
        end
        return e[127:64];
    endfunction

    function automatic logic [63:0] pt(input int k);
        case (k)
            0:       return 64'h0;
            1:       return 64'h0123_4567_89AB_CDEF;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return 64'(k) + 64'h100;
        endcase
    endfunction

    function automatic logic [1:0] hdr_of(input int k);
        return (k % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic step(input logic [63:0] p, input logic [1:0] h, input bit vld,
                        input bit lock, input bit clr);
        logic [63:0] s;
        bit          run;
        exp_t        e;
        s = vld ? scramble(p, scr_prev) : {p[31:0], ~p[63:32]};
        dif.in_data       = s;
        dif.in_header     = h;
        dif.in_data_valid = vld;
        block_lock        = lock;
        err_count_clr     = clr;
        if (vld) scr_prev = s;
        run = lock && vld && seeded;
        if (!lock) seeded = 1'b0;
        else if (vld) seeded = 1'b1;
        if (run) begin
            e.data = p;
            e.hdr  = h;
            e.err  = is_bad(h);
            sb.push_back(e);
        end
        if (clr) m_cnt = (run && is_bad(h)) ? 1 : 0;
        else if (run && is_bad(h) && m_cnt < 15) m_cnt++;
        if (!lock) begin
            m_wc = 0;
            m_we = 0;
        end else if (run) begin
            if (is_bad(h) && m_we < 3) m_we++;
            if (m_we >= 3) m_hi = 1'b1;
            if (m_wc == 7) begin
                if (m_we < 3) m_hi = 1'b0;
                m_wc = 0;
                m_we = 0;
            end else begin
                m_wc++;
            end
        end
        @(posedge clk);
        #1;
        chk("out_data_valid", 64'(dif.out_data_valid), 64'(run));
        if (dif.out_data_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard: unexpected output %h, expected none", dif.out_data);
            end else begin
                e = sb.pop_front();
                chk("out_data", dif.out_data, e.data);
                chk("out_header", 64'(dif.out_header), 64'(e.hdr));
                chk("out_hdr_err", 64'(dif.out_hdr_err), 64'(e.err));
            end
        end
        chk("err_count", 64'(err_count), 64'(m_cnt));
        chk("hi_ber", 64'(hi_ber), 64'(m_hi));
    endtask

    // Asserted between clock edges; outputs must clear with no edge in between.
    task automatic do_reset();
        rst           = 1'b0;
        block_lock    = 1'b0;
        err_count_clr = 1'b0;
        #2;
        chk("rst_out_data_valid", 64'(dif.out_data_valid), 64'd0);
        chk("rst_out_data", dif.out_data, 64'd0);
        chk("rst_out_header", 64'(dif.out_header), 64'd0);
        chk("rst_out_hdr_err", 64'(dif.out_hdr_err), 64'd0);
        chk("rst_hi_ber", 64'(hi_ber), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        seeded   = 1'b0;
        m_cnt    = 0;
        m_wc     = 0;
        m_we     = 0;
        m_hi     = 1'b0;
        scr_prev = '1;
        sb.delete();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        dif.in_data       = '0;
        dif.in_header     = 2'b01;
        dif.in_data_valid = 1'b0;
        tv[0] = '{2'b01, 1'b0, 4'd0};
        tv[1] = '{2'b00, 1'b1, 4'd1};
        tv[2] = '{2'b10, 1'b0, 4'd1};
        tv[3] = '{2'b01, 1'b0, 4'd1};
        tv[4] = '{2'b11, 1'b1, 4'd2};
        tv[5] = '{2'b10, 1'b0, 4'd2};

        do_reset();

        // Loopback, first block is seed
        for (int k = 0; k < 20; k++) step(pt(k), hdr_of(k), 1'b1, 1'b1, 1'b0);

        // Same stream with alternating gaps
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(pt(k), hdr_of(k), 1'b1, 1'b1, 1'b0);
            step(pt(k + 50), 2'b11, 1'b0, 1'b1, 1'b0);
        end

        // Header error table
        do_reset();
        step(64'h0, 2'b01, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(64'hA5A5_0000 + 64'(i), tv[i].hdr, 1'b1, 1'b1, 1'b0);
            chk("tbl_hdr_err", 64'(dif.out_hdr_err), 64'(tv[i].exp_err));
            chk("tbl_err_count", 64'(err_count), 64'(tv[i].exp_cnt));
        end

        // hi_ber windows of 8, threshold 3
        do_reset();
        step(64'h0, 2'b01, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(64'h1000 + 64'(i), (i < 3) ? ((i == 1) ? 2'b11 : 2'b00) : 2'b01,
                 1'b1, 1'b1, 1'b0);
            if (i == 1) chk("hi_ber_before_thresh", 64'(hi_ber), 64'd0);
            if (i == 2) chk("hi_ber_set", 64'(hi_ber), 64'd1);
        end
        chk("hi_ber_after_bad_window", 64'(hi_ber), 64'd1);
        for (int i = 0; i < 8; i++) begin
            step(64'h2000 + 64'(i), 2'b10, 1'b1, 1'b1, 1'b0);
            if (i == 6) chk("hi_ber_held_in_clean", 64'(hi_ber), 64'd1);
        end
        chk("hi_ber_cleared", 64'(hi_ber), 64'd0);
        for (int i = 0; i < 8; i++) begin
            step(64'h3000 + 64'(i), (i == 1 || i == 5) ? 2'b11 : 2'b01, 1'b1, 1'b1, 1'b0);
        end
        chk("hi_ber_two_errors", 64'(hi_ber), 64'd0);
        chk("err_count_after_windows", 64'(err_count), 64'd5);

        // Lock drop and relock
        step(64'h4000, 2'b01, 1'b1, 1'b1, 1'b0);
        step(64'h4001, 2'b01, 1'b1, 1'b0, 1'b0);
        chk("lock_drop_valid", 64'(dif.out_data_valid), 64'd0);
        step(64'h4002, 2'b00, 1'b1, 1'b0, 1'b0);
        step(64'h4003, 2'b01, 1'b1, 1'b1, 1'b0);
        chk("relock_seed_suppressed", 64'(dif.out_data_valid), 64'd0);
        step(64'h4004, 2'b10, 1'b1, 1'b1, 1'b0);
        chk("relock_decode", dif.out_data, 64'h4004);
        chk("relock_err_count", 64'(err_count), 64'd5);

        // Saturation, clear priority, async reset
        do_reset();
        step(64'h0, 2'b01, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(64'h5000 + 64'(i), i[0] ? 2'b11 : 2'b00, 1'b1, 1'b1, 1'b0);
        end
        chk("err_count_saturated", 64'(err_count), 64'd15);
        step(64'h6000, 2'b00, 1'b1, 1'b1, 1'b1);
        chk("clr_with_error", 64'(err_count), 64'd1);
        step(64'h6001, 2'b01, 1'b1, 1'b1, 1'b0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
